// File: rtl/buzz_sched_pkg.sv
// buzz_sched_pkg: shared state encoding, owner codes and time constants for the buzzer scheduler
package buzz_sched_pkg;
  typedef enum logic [2:0] {IDLE, CLICK, CHIME, RING_ON, RING_OFF, SNOOZE} state_t;
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_CLICK = 2'd1;
  localparam logic [1:0] SRC_CHIME = 2'd2;
  localparam logic [1:0] SRC_ALARM = 2'd3;
  localparam int MS_PER_S = 1000;
  function automatic logic is_ring(state_t s);
    return s == RING_ON || s == RING_OFF;
  endfunction
endpackage

// File: rtl/buzz_sched_ms_tick_gen.sv
// ms_tick_gen: divides clk by MS_DIV into a 1-cycle tick, restartable by a synchronous clear
module ms_tick_gen #(
  parameter int MS_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int PW = MS_DIV > 1 ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(MS_DIV - 1);
  logic [PW-1:0] pre;
  assign tick = pre == LAST;
  // prescaler restarts on clear so the first tick arrives MS_DIV cycles after a state entry
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= (clr || tick) ? '0 : pre + 1'b1;
endmodule

// File: rtl/buzz_sched.sv
// buzz_sched: arbitrates the buzzer between alarm ring, hourly chime and key click
module buzz_sched
  import buzz_sched_pkg::*;
#(
  parameter int MS_DIV      = 50000,
  parameter int CLICK_MS    = 30,
  parameter int CHIME_MS    = 200,
  parameter int RING_ON_MS  = 500,
  parameter int RING_OFF_MS = 500,
  parameter int RING_S      = 60,
  parameter int SNOOZE_S    = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_alarm_en,
  input  logic       i_alarm_hit,
  input  logic       i_hour_wrap,
  input  logic       i_key_pulse,
  input  logic       i_snooze,
  input  logic       i_dismiss,
  output logic       o_buzz_en,
  output logic [1:0] o_src,
  output logic       o_ringing,
  output logic       o_snoozed
);
  localparam int MW = $clog2(MS_PER_S);
  localparam int SMAX = RING_S > SNOOZE_S ? RING_S : SNOOZE_S;
  localparam int SW = $clog2(SMAX + 1);
  localparam logic [MW-1:0] CLICK_T = MW'(CLICK_MS - 1);
  localparam logic [MW-1:0] CHIME_T = MW'(CHIME_MS - 1);
  localparam logic [MW-1:0] ON_T = MW'(RING_ON_MS - 1);
  localparam logic [MW-1:0] OFF_T = MW'(RING_OFF_MS - 1);
  localparam logic [MW-1:0] SUB_T = MW'(MS_PER_S - 1);
  localparam logic [SW-1:0] RING_T = SW'(RING_S - 1);
  localparam logic [SW-1:0] SNOOZE_T = SW'(SNOOZE_S - 1);
  state_t state, nxt;
  logic hit_q, trig, tick, clr, sclr, timed, sec_wrap, stop;
  logic [MW-1:0] ms_cnt, sub_ms;
  logic [SW-1:0] sec;
  assign trig = i_alarm_hit && !hit_q && i_alarm_en;
  assign stop = i_dismiss || !i_alarm_en;
  assign timed = is_ring(state) || state == SNOOZE;
  assign sec_wrap = tick && sub_ms == SUB_T;
  assign clr = nxt != state;
  assign sclr = clr && !(is_ring(state) && is_ring(nxt));
  ms_tick_gen #(.MS_DIV(MS_DIV)) u_tick (.clk(clk), .rst(rst), .clr(clr), .tick(tick));
  // next-state selection; earlier branches win when requests coincide
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = trig ? RING_ON : i_hour_wrap ? CHIME : i_key_pulse ? CLICK : IDLE;
      CLICK:    nxt = trig ? RING_ON : i_hour_wrap ? CHIME : (tick && ms_cnt == CLICK_T) ? IDLE : CLICK;
      CHIME:    nxt = trig ? RING_ON : (tick && ms_cnt == CHIME_T) ? IDLE : CHIME;
      RING_ON:  nxt = stop ? IDLE : i_snooze ? SNOOZE : (sec_wrap && sec == RING_T) ? IDLE :
                      (tick && ms_cnt == ON_T) ? RING_OFF : RING_ON;
      RING_OFF: nxt = stop ? IDLE : i_snooze ? SNOOZE : (sec_wrap && sec == RING_T) ? IDLE :
                      (tick && ms_cnt == OFF_T) ? RING_ON : RING_OFF;
      SNOOZE:   nxt = stop ? IDLE : (sec_wrap && sec == SNOOZE_T) ? RING_ON : SNOOZE;
      default:  nxt = IDLE;
    endcase
  end
  // alarm edge register starts high so a hit already present at reset release is ignored
  always_ff @(posedge clk or posedge rst)
    if (rst) hit_q <= 1'b1;
    else hit_q <= i_alarm_hit;
  // phase ms counter restarts on every state change; second timebase survives ring on/off toggles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ms_cnt <= '0;
      sub_ms <= '0;
      sec <= '0;
    end else begin
      ms_cnt <= clr ? '0 : (tick && state != IDLE) ? ms_cnt + 1'b1 : ms_cnt;
      sub_ms <= sclr ? '0 : (tick && timed) ? (sec_wrap ? '0 : sub_ms + 1'b1) : sub_ms;
      sec <= sclr ? '0 : (sec_wrap && timed) ? sec + 1'b1 : sec;
    end
  // state register with outputs decoded from the next state so they change together with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      o_buzz_en <= 1'b0;
      o_src <= SRC_NONE;
      o_ringing <= 1'b0;
      o_snoozed <= 1'b0;
    end else begin
      state <= nxt;
      o_buzz_en <= nxt == CLICK || nxt == CHIME || nxt == RING_ON;
      o_src <= nxt == IDLE ? SRC_NONE : nxt == CLICK ? SRC_CLICK : nxt == CHIME ? SRC_CHIME : SRC_ALARM;
      o_ringing <= is_ring(nxt);
      o_snoozed <= nxt == SNOOZE;
    end
endmodule

// File: tb/tb_buzz_sched.sv
// tb_buzz_sched: directed checks of priority, timing, snooze, dismiss and reset behaviour
module tb_buzz_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic alarm_en = 1'b0, alarm_hit = 1'b0, hour_wrap = 1'b0, key_pulse = 1'b0, snooze = 1'b0, dismiss = 1'b0;
  logic buzz_en, ringing, snoozed;
  logic [1:0] src;
  int total = 0, bad = 0;

  buzz_sched #(.MS_DIV(4), .CLICK_MS(2), .CHIME_MS(3), .RING_ON_MS(2), .RING_OFF_MS(2),
               .RING_S(2), .SNOOZE_S(1)) dut (
    .clk(clk), .rst(rst), .i_alarm_en(alarm_en), .i_alarm_hit(alarm_hit), .i_hour_wrap(hour_wrap),
    .i_key_pulse(key_pulse), .i_snooze(snooze), .i_dismiss(dismiss),
    .o_buzz_en(buzz_en), .o_src(src), .o_ringing(ringing), .o_snoozed(snoozed));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic click_run(int again);
    @(negedge clk);
    key_pulse = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      key_pulse = (k == again);
      chk("click_buzz", buzz_en, k <= 8);
      chk("click_src", src, k <= 8 ? 1 : 0);
    end
    key_pulse = 1'b0;
  endtask

  task automatic arm_ring();
    alarm_hit = 1'b0;
    @(negedge clk);
    alarm_hit = 1'b1;
    @(negedge clk);
    chk("ring_start", ringing, 1);
    chk("ring_start_buzz", buzz_en, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_buzz", buzz_en, 0);
    chk("rst_src", src, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozed", snoozed, 0);
    rst = 1'b0;
    alarm_en = 1'b1;
    click_run(3);
    @(negedge clk);
    key_pulse = 1'b1;
    hour_wrap = 1'b1;
    alarm_hit = 1'b1;
    @(negedge clk);
    key_pulse = 1'b0;
    hour_wrap = 1'b0;
    chk("prio_src", src, 3);
    chk("prio_ringing", ringing, 1);
    chk("prio_buzz", buzz_en, 1);
    dismiss = 1'b1;
    @(negedge clk);
    dismiss = 1'b0;
    chk("dismiss_src", src, 0);
    chk("dismiss_ringing", ringing, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_queue_src", src, 0);
    end
    alarm_hit = 1'b0;
    @(negedge clk);
    hour_wrap = 1'b1;
    @(negedge clk);
    hour_wrap = 1'b0;
    chk("chime_src", src, 2);
    chk("chime_buzz", buzz_en, 1);
    repeat (4) @(negedge clk);
    chk("chime_c5_src", src, 2);
    alarm_hit = 1'b1;
    for (int j = 1; j <= 8001; j++) begin
      @(negedge clk);
      chk("ring_pattern", buzz_en, j <= 8000 && ((j - 1) / 8) % 2 == 0);
      if (j == 1) chk("preempt_src", src, 3);
      if (j == 9) chk("ring_off_ringing", ringing, 1);
      if (j == 8000) chk("ring_end_ringing", ringing, 1);
      if (j == 8001) begin
        chk("timeout_ringing", ringing, 0);
        chk("timeout_src", src, 0);
      end
    end
    arm_ring();
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    chk("snooze_flag", snoozed, 1);
    chk("snooze_ringing", ringing, 0);
    chk("snooze_buzz", buzz_en, 0);
    for (int k = 2; k <= 4001; k++) begin
      @(negedge clk);
      key_pulse = (k == 10);
      hour_wrap = (k == 20);
      if (k <= 4000) begin
        chk("snooze_hold_buzz", buzz_en, 0);
        chk("snooze_hold_flag", snoozed, 1);
      end
    end
    chk("rering_ringing", ringing, 1);
    chk("rering_buzz", buzz_en, 1);
    chk("rering_snoozed", snoozed, 0);
    dismiss = 1'b1;
    @(negedge clk);
    dismiss = 1'b0;
    chk("dismiss2_src", src, 0);
    chk("dismiss2_ringing", ringing, 0);
    arm_ring();
    alarm_en = 1'b0;
    @(negedge clk);
    chk("disarm_ringing", ringing, 0);
    chk("disarm_src", src, 0);
    chk("disarm_buzz", buzz_en, 0);
    alarm_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hit_through_reset", ringing, 0);
    end
    arm_ring();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_buzz", buzz_en, 0);
    chk("async_src", src, 0);
    chk("async_ringing", ringing, 0);
    chk("async_snoozed", snoozed, 0);
    @(negedge clk);
    rst = 1'b0;
    alarm_hit = 1'b0;
    click_run(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
